// File: rtl/io_bus_fabric.sv
// ============================================================================
// Module   : io_bus_fabric
// Purpose  : Memory-mapped I/O interconnect between the CPU memory port and
//            NSLAVES peripherals. Each access is decoded by base/mask with a
//            lowest-index-wins priority, then forwarded over a registered
//            valid/ready handshake. Unmatched or hung accesses receive a
//            bounded error response.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module io_bus_fabric #(
  parameter int                          NSLAVES       = 8,
  parameter int                          ADDR_W        = 32,
  parameter int                          DATA_W        = 32,
  parameter logic [NSLAVES*ADDR_W-1:0]   BASE          = '0,
  parameter logic [NSLAVES*ADDR_W-1:0]   MASK          = '0,
  parameter int                          TIMEOUT       = 255,
  parameter bit                          FAULT_ON_MISS = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  // CPU side
  input  logic                        m_valid,
  input  logic [ADDR_W-1:0]           m_addr,
  input  logic [DATA_W-1:0]           m_wdata,
  input  logic [DATA_W/8-1:0]         m_wstrb,
  output logic                        m_ready,
  output logic [DATA_W-1:0]           m_rdata,
  output logic                        m_fault,
  // Peripheral side
  output logic [NSLAVES-1:0]          s_valid,
  output logic [ADDR_W-1:0]           s_addr,
  output logic [DATA_W-1:0]           s_wdata,
  output logic [DATA_W/8-1:0]         s_wstrb,
  input  logic [NSLAVES-1:0]          s_ready,
  input  logic [NSLAVES*DATA_W-1:0]   s_rdata,
  output logic                        busy
);

  // Slave index and timeout counter widths; both kept at least one bit wide
  // so degenerate parameterisations (one slave, no timeout) still elaborate.
  localparam int SEL_W = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
  logic [NSLAVES-1:0]  s_valid_q, s_valid_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                fault_q, fault_d;

  logic                hit;
  logic [SEL_W-1:0]    hit_idx;
  logic [DATA_W-1:0]   sel_rdata;

  // Address decode: scan from the top index down so the lowest hit wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NSLAVES - 1; i >= 0; i--) begin
      if ((m_addr & MASK[i*ADDR_W +: ADDR_W]) == BASE[i*ADDR_W +: ADDR_W]) begin
        hit     = 1'b1;
        hit_idx = SEL_W'(i);
      end
    end
  end

  // Read data of the currently selected slave.
  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NSLAVES; i++) begin
      if (sel_q == SEL_W'(i)) begin
        sel_rdata = s_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // State and datapath registers; reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      s_valid_q <= '0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      s_valid_q <= s_valid_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      fault_q   <= fault_d;
    end
  end

  // Next-state logic: accept in IDLE, wait for the slave or the timeout,
  // then present a single-cycle response.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    s_valid_d = s_valid_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    fault_d   = fault_q;

    unique case (state_q)
      ST_IDLE: begin
        if (m_valid) begin
          addr_d  = m_addr;
          wdata_d = m_wdata;
          wstrb_d = m_wstrb;
          sel_d   = hit_idx;
          if (hit) begin
            state_d            = ST_WAIT;
            s_valid_d          = '0;
            s_valid_d[hit_idx] = 1'b1;
          end else begin
            state_d = ST_RESP;
            rdata_d = '0;
            fault_d = FAULT_ON_MISS;
          end
        end
      end

      ST_WAIT: begin
        // Counter saturates rather than wrapping.
        if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
        // Slave completion takes precedence over a coincident timeout.
        if (s_ready[sel_q]) begin
          state_d   = ST_RESP;
          s_valid_d = '0;
          rdata_d   = sel_rdata;
          fault_d   = 1'b0;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          state_d   = ST_RESP;
          s_valid_d = '0;
          rdata_d   = '0;
          fault_d   = 1'b1;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        rdata_d = '0;
        fault_d = 1'b0;
      end

      default: begin
        state_d   = ST_IDLE;
        s_valid_d = '0;
        cnt_d     = '0;
        rdata_d   = '0;
        fault_d   = 1'b0;
      end
    endcase
  end

  // rdata_q/fault_q are only non-zero while in RESP, so the response
  // outputs are naturally zero whenever m_ready is low.
  assign m_ready = (state_q == ST_RESP);
  assign m_rdata = rdata_q;
  assign m_fault = fault_q;
  assign s_valid = s_valid_q;
  assign s_addr  = addr_q;
  assign s_wdata = wdata_q;
  assign s_wstrb = wstrb_q;
  assign busy    = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_io_bus_fabric.sv
// ============================================================================
// Module   : tb_io_bus_fabric
// Purpose  : Self-checking bench for io_bus_fabric: table of transactions
//            with a response scoreboard, plus hand-written reset, early
//            m_valid drop and silent-miss sequences.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_io_bus_fabric;

  localparam int NS = 4;
  localparam int TO = 8;
  localparam logic [NS*32-1:0] P_BASE = {32'h1100_0000, 32'h1000_0000, 32'h3000_0000, 32'h1100_0000};
  localparam logic [NS*32-1:0] P_MASK = {32'hFFFF_0000, 32'hFFFF_FFF0, 32'hFFFF_0000, 32'hFFF0_0000};

  logic             clk = 1'b0;
  logic             rst_n;
  logic             m_valid;
  logic [31:0]      m_addr;
  logic [31:0]      m_wdata;
  logic [3:0]       m_wstrb;
  logic             m_ready;
  logic [31:0]      m_rdata;
  logic             m_fault;
  logic [NS-1:0]    s_valid;
  logic [31:0]      s_addr;
  logic [31:0]      s_wdata;
  logic [3:0]       s_wstrb;
  logic [NS-1:0]    s_ready;
  logic [NS*32-1:0] s_rdata;
  logic             busy;

  // Second instance with FAULT_ON_MISS=0; its slaves never respond.
  logic             nf_valid;
  logic             nf_ready;
  logic [31:0]      nf_rdata;
  logic             nf_fault;
  logic [NS-1:0]    nf_svalid;
  logic [31:0]      nf_saddr;
  logic [31:0]      nf_swdata;
  logic [3:0]       nf_swstrb;
  logic [NS-1:0]    nf_sready;
  logic [NS*32-1:0] nf_srdata;
  logic             nf_busy;

  always #5 clk = ~clk;

  io_bus_fabric #(.NSLAVES(NS), .ADDR_W(32), .DATA_W(32), .BASE(P_BASE), .MASK(P_MASK),
                  .TIMEOUT(TO), .FAULT_ON_MISS(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_ready(m_ready), .m_rdata(m_rdata), .m_fault(m_fault),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_ready(s_ready), .s_rdata(s_rdata), .busy(busy)
  );

  io_bus_fabric #(.NSLAVES(NS), .ADDR_W(32), .DATA_W(32), .BASE(P_BASE), .MASK(P_MASK),
                  .TIMEOUT(TO), .FAULT_ON_MISS(1'b0)) dut_nf (
    .clk(clk), .rst_n(rst_n),
    .m_valid(nf_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_ready(nf_ready), .m_rdata(nf_rdata), .m_fault(nf_fault),
    .s_valid(nf_svalid), .s_addr(nf_saddr), .s_wdata(nf_swdata), .s_wstrb(nf_swstrb),
    .s_ready(nf_sready), .s_rdata(nf_srdata), .busy(nf_busy)
  );

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          sel;       // expected selected slave, -1 for a miss
    int          lat;       // cycle Tk at which the slave readies, -1 = never
    logic [31:0] srdata;    // data returned by the selected slave
    logic [3:0]  noise;     // s_ready bits of other slaves held high throughout
    bit          drop;      // master drops m_valid after T1
    logic [31:0] exp_rdata;
    logic        exp_fault;
    int          exp_cyc;   // cycle index of m_ready relative to accept at T0
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          cyc;
  } resp_t;

  vec_t  vecs[8];
  resp_t sb[$];
  int    errors = 0;
  int    checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One full transaction: drive at T0, model the slave, score the response.
  task automatic run_txn(input vec_t v);
    resp_t r;
    int    cyc;
    bit    done;
    logic [NS-1:0] exp_sv;
    @(negedge clk);
    m_valid = 1'b1;
    m_addr  = v.addr;
    m_wdata = v.wdata;
    m_wstrb = v.wstrb;
    s_ready = v.noise;
    for (int j = 0; j < NS; j++)
      s_rdata[j*32 +: 32] = (j == v.sel) ? v.srdata : (32'hBAD0_0000 | 32'(j));
    sb.push_back('{v.exp_rdata, v.exp_fault, v.exp_cyc});
    cyc  = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      cyc++;
      exp_sv = '0;
      if (v.sel >= 0 && !m_ready) exp_sv[v.sel] = 1'b1;
      chk({v.name, " s_valid"}, 32'(s_valid), 32'(exp_sv));
      if (m_ready) begin
        done = 1'b1;
        if (sb.size() == 0) begin
          chk({v.name, " unexpected m_ready"}, 32'd1, 32'd0);
        end else begin
          r = sb.pop_front();
          chk({v.name, " m_rdata"}, m_rdata, r.rdata);
          chk({v.name, " m_fault"}, 32'(m_fault), 32'(r.fault));
          chk({v.name, " latency"}, 32'(cyc), 32'(r.cyc));
        end
        m_valid = 1'b0;
        s_ready = '0;
      end else if (cyc > 40) begin
        chk({v.name, " m_ready within 40 cycles"}, 32'd0, 32'd1);
        void'(sb.pop_front());
        m_valid = 1'b0;
        s_ready = '0;
        done    = 1'b1;
      end else begin
        if (cyc == 1 && v.sel >= 0) begin
          chk({v.name, " s_addr"},  s_addr, v.addr);
          chk({v.name, " s_wdata"}, s_wdata, v.wdata);
          chk({v.name, " s_wstrb"}, 32'(s_wstrb), 32'(v.wstrb));
          chk({v.name, " busy"},    32'(busy), 32'd1);
        end
        if (v.drop) m_valid = 1'b0;
        s_ready = v.noise;
        if (v.sel >= 0 && cyc == v.lat) s_ready[v.sel] = 1'b1;
      end
    end
    @(negedge clk);
    chk({v.name, " m_ready pulse width"}, 32'(m_ready), 32'd0);
    chk({v.name, " m_rdata idle"}, m_rdata, 32'd0);
    chk({v.name, " busy idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    // name, addr, wdata, wstrb, sel, lat, srdata, noise, drop, exp_rdata, exp_fault, exp_cyc
    vecs[0] = '{"read_hit",   32'h1000_0004, 32'h0,         4'h0, 2, 4,  32'hA5A5_0001, 4'h0, 1'b0, 32'hA5A5_0001, 1'b0, 5};
    vecs[1] = '{"write",      32'h1000_0000, 32'h0000_00C3, 4'h1, 2, 1,  32'h0,         4'h0, 1'b0, 32'h0,         1'b0, 2};
    vecs[2] = '{"overlap",    32'h1100_0000, 32'h0,         4'h0, 0, 2,  32'h1234_5678, 4'h8, 1'b0, 32'h1234_5678, 1'b0, 3};
    vecs[3] = '{"miss",       32'h2000_0000, 32'h0,         4'h0, -1, -1, 32'h0,        4'hF, 1'b0, 32'h0,         1'b1, 1};
    vecs[4] = '{"timeout",    32'h3000_0000, 32'h0,         4'h0, 1, -1, 32'h5555_5555, 4'h0, 1'b0, 32'h0,         1'b1, TO + 1};
    vecs[5] = '{"ready_at_8", 32'h3000_0004, 32'h0,         4'h0, 1, TO, 32'hDEAD_BEEF, 4'h0, 1'b0, 32'hDEAD_BEEF, 1'b0, TO + 1};
    vecs[6] = '{"s0_fast",    32'h1100_0010, 32'hFFFF_0000, 4'hC, 0, 1,  32'h0000_CAFE, 4'h6, 1'b0, 32'h0000_CAFE, 1'b0, 2};
    vecs[7] = '{"valid_drop", 32'h1000_000C, 32'h0,         4'h0, 2, 3,  32'h0000_7777, 4'h0, 1'b1, 32'h0000_7777, 1'b0, 4};

    rst_n     = 1'b0;
    m_valid   = 1'b0;
    m_addr    = '0;
    m_wdata   = '0;
    m_wstrb   = '0;
    s_ready   = '0;
    s_rdata   = '0;
    nf_valid  = 1'b0;
    nf_sready = '0;
    nf_srdata = '0;
    repeat (2) @(negedge clk);
    chk("reset m_ready", 32'(m_ready), 32'd0);
    chk("reset s_valid", 32'(s_valid), 32'd0);
    chk("reset m_rdata/m_fault/busy", {m_rdata[30:0], m_fault} | 32'(busy), 32'd0);
    chk("reset s_addr", s_addr, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_txn(vecs[i]);

    // Reset while waiting on a slave aborts the access silently.
    @(negedge clk);
    m_valid = 1'b1;
    m_addr  = 32'h1000_0004;
    m_wstrb = 4'h0;
    repeat (3) @(negedge clk);
    chk("pre-reset s_valid", 32'(s_valid), 32'h4);
    rst_n   = 1'b0;
    m_valid = 1'b0;
    @(negedge clk);
    chk("mid-reset m_ready", 32'(m_ready), 32'd0);
    chk("mid-reset s_valid", 32'(s_valid), 32'd0);
    chk("mid-reset busy", 32'(busy), 32'd0);
    chk("mid-reset s_addr", s_addr, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post-reset no m_ready", 32'(m_ready), 32'd0);
    end
    run_txn(vecs[0]);

    // Silent miss on the FAULT_ON_MISS=0 instance.
    @(negedge clk);
    nf_valid = 1'b1;
    m_addr   = 32'h2000_0000;
    @(negedge clk);
    chk("nf m_ready", 32'(nf_ready), 32'd1);
    chk("nf m_fault", 32'(nf_fault), 32'd0);
    chk("nf m_rdata", nf_rdata, 32'd0);
    chk("nf s_valid", 32'(nf_svalid), 32'd0);
    nf_valid = 1'b0;
    @(negedge clk);
    chk("nf m_ready pulse", 32'(nf_ready), 32'd0);

    chk("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule

`default_nettype wire
